// File: rtl/jtag_pkg.sv
// Shared JTAG types: target TAP controller states, host command opcodes,
// host sequencer states and the IEEE 1149.1 TMS transition function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR_SCAN, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR_SCAN, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_ctrl_fsm_t;

  typedef enum logic [1:0] {
    HOST_RESET    = 2'd0,
    HOST_SHIFT_IR = 2'd1,
    HOST_SHIFT_DR = 2'd2
  } host_cmd_t;

  typedef enum logic [1:0] {H_IDLE, H_RUN, H_SHIFT, H_RESP} host_state_t;

  function automatic tap_ctrl_fsm_t tap_next_state(input tap_ctrl_fsm_t s, input logic tms);
    tap_ctrl_fsm_t n;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: tck toggles every CLK_DIV enabled clk cycles. The rise/fall
// strobes flag the clk edge on which tck is about to change.
module jtag_tck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic trstn,
  input  logic en,
  output logic tck_o,
  output logic tck_rise_c,
  output logic tck_fall_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tck_q, tck_d;
  logic             wrap;

  assign wrap       = en && (cnt_q == DIV_W'(CLK_DIV - 1));
  assign tck_rise_c = wrap && !tck_q;
  assign tck_fall_c = wrap && tck_q;
  assign tck_o      = tck_q;

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      tck_d = !tck_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge trstn) begin
    if (!trstn) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_host_shifter.sv
// JTAG TAP master: walks the target TAP through RESET / SHIFT_IR / SHIFT_DR
// sequences, shifts tdi LSB-first and returns the sampled tdo bits.
module jtag_host_shifter
  import jtag_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               trstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  host_cmd_t          cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  output tap_ctrl_fsm_t      tap_state_o
);

  localparam int unsigned SEQ_W = MAX_LEN + 8;
  localparam int unsigned CNT_W = $clog2(SEQ_W + 1);

  host_state_t        state_q, state_d;
  tap_ctrl_fsm_t      tap_state_q, tap_state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [SEQ_W-1:0]   tms_seq_q, tms_seq_d;
  logic               tms_q, tms_d, tdi_q, tdi_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d, total_q, total_d, start_q, start_d, len_q, len_d;
  logic [CNT_W-1:0]   hdr;
  logic [SEQ_W-1:0]   seq;
  logic               tck_en, tck_rise_c, tck_fall_c;

  assign tck_en = (state_q == H_RUN) || (state_q == H_SHIFT);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk        (clk),
    .trstn      (trstn),
    .en         (tck_en),
    .tck_o      (tck_o),
    .tck_rise_c (tck_rise_c),
    .tck_fall_c (tck_fall_c)
  );

  function automatic logic in_win(input logic [CNT_W-1:0] k, input logic [CNT_W-1:0] s,
                                  input logic [CNT_W-1:0] n);
    return (k >= s) && (k < s + n);
  endfunction

  always_comb begin
    state_d     = state_q;
    tap_state_d = tap_state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    data_d      = data_q;
    tms_seq_d   = tms_seq_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cyc_d       = cyc_q;
    total_d     = total_q;
    start_d     = start_q;
    len_d       = len_q;
    hdr         = '0;
    seq         = '0;

    case (state_q)
      H_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          data_d      = cmd_data;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          cyc_d       = '0;
          tdi_d       = 1'b0;
          if (cmd_op != HOST_RESET && (cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN))) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = H_RESP;
          end else begin
            // tms_seq bit k is the TMS value of tck cycle k
            if (cmd_op == HOST_RESET) begin
              seq     = SEQ_W'(5'b11111);
              total_d = CNT_W'(6);
              start_d = '0;
              len_d   = '0;
            end else begin
              hdr     = (cmd_op == HOST_SHIFT_IR) ? CNT_W'(4) : CNT_W'(3);
              len_d   = CNT_W'(cmd_len);
              seq     = ((cmd_op == HOST_SHIFT_IR) ? SEQ_W'(2'b11) : SEQ_W'(1'b1))
                      | (SEQ_W'(2'b11) << (hdr + len_d - CNT_W'(1)));
              total_d = hdr + len_d + CNT_W'(2);
              start_d = hdr;
              if (tap_state_q == TEST_LOGIC_RESET) begin
                seq     = seq << 1;
                total_d = total_d + CNT_W'(1);
                start_d = start_d + CNT_W'(1);
              end
            end
            tms_seq_d = seq;
            tms_d     = seq[0];
            state_d   = H_RUN;
          end
        end
      end

      H_RUN, H_SHIFT: begin
        if (tck_rise_c) begin
          tap_state_d = tap_next_state(tap_state_q, tms_q);
          if (tap_state_q == SHIFT_DR || tap_state_q == SHIFT_IR)
            rsp_data_d = rsp_data_q | (MAX_LEN'(tdo_i) << (cyc_q - start_q));
        end
        if (tck_fall_c) begin
          if (cyc_q == total_q - CNT_W'(1)) begin
            tms_d       = 1'b0;
            tdi_d       = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = H_RESP;
          end else begin
            cyc_d     = cyc_q + CNT_W'(1);
            tms_seq_d = tms_seq_q >> 1;
            tms_d     = tms_seq_d[0];
            if (in_win(cyc_q, start_q, len_q))
              data_d = data_q >> 1;
            if (in_win(cyc_d, start_q, len_q)) begin
              tdi_d   = data_d[0];
              state_d = H_SHIFT;
            end else begin
              tdi_d   = 1'b0;
              state_d = H_RUN;
            end
          end
        end
      end

      H_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = H_IDLE;
        end
      end

      default: state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge trstn) begin
    if (!trstn) begin
      state_q     <= H_IDLE;
      tap_state_q <= TEST_LOGIC_RESET;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      data_q      <= '0;
      tms_seq_q   <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cyc_q       <= '0;
      total_q     <= '0;
      start_q     <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      tap_state_q <= tap_state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      data_q      <= data_d;
      tms_seq_q   <= tms_seq_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cyc_q       <= cyc_d;
      total_q     <= total_d;
      start_q     <= start_d;
      len_q       <= len_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_data    = rsp_data_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;
  assign tap_state_o = tap_state_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Bench for jtag_host_shifter: a behavioural TAP target drives tdo, expected
// responses go into a queue and a monitor checks each response transfer.
module tb_jtag_host_shifter;
  import jtag_pkg::*;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned LEN_W   = 6;

  logic               clk, trstn;
  logic               cmd_valid, cmd_ready;
  host_cmd_t          cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid, rsp_ready, rsp_err;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck_o, tms_o, tdi_o, tdo_i;
  tap_ctrl_fsm_t      tap_state_o;

  jtag_host_shifter #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .trstn(trstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i), .tap_state_o(tap_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic err; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0, n_fail = 0, n_rsp = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Independent TAP target model: mode 0 = 1-bit bypass, 1 = tdo tied high, 2 = 32-bit DR
  tap_ctrl_fsm_t tb_state;
  logic [31:0]   tb_dr, ir_tdi;
  logic [15:0]   tms_hist;
  int            mode, tck_cnt, ir_n, dr_n, tdi_bad;

  function automatic tap_ctrl_fsm_t tb_next(input tap_ctrl_fsm_t s, input logic m);
    case (s)
      TEST_LOGIC_RESET: return m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE, UPDATE_DR, UPDATE_IR: return m ? SELECT_DR_SCAN : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   return m ? SELECT_IR_SCAN : CAPTURE_DR;
      SELECT_IR_SCAN:   return m ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR, SHIFT_DR, EXIT2_DR: return m ? EXIT1_DR : SHIFT_DR;
      CAPTURE_IR, SHIFT_IR, EXIT2_IR: return m ? EXIT1_IR : SHIFT_IR;
      EXIT1_DR:         return m ? UPDATE_DR : PAUSE_DR;
      EXIT1_IR:         return m ? UPDATE_IR : PAUSE_IR;
      PAUSE_DR:         return m ? EXIT2_DR : PAUSE_DR;
      PAUSE_IR:         return m ? EXIT2_IR : PAUSE_IR;
      default:          return TEST_LOGIC_RESET;
    endcase
  endfunction

  always @(posedge tck_o or negedge trstn) begin
    if (!trstn) begin
      tb_state = TEST_LOGIC_RESET;
    end else begin
      tck_cnt++;
      tms_hist = {tms_hist[14:0], tms_o};
      if (tdi_o && tb_state != SHIFT_DR && tb_state != SHIFT_IR) tdi_bad++;
      if (tb_state == SHIFT_IR && ir_n < 32) begin
        ir_tdi[ir_n] = tdi_o;
        ir_n++;
      end
      if (tb_state == CAPTURE_DR) begin
        tb_dr = (mode == 2) ? 32'hDEADBEEF : 32'h0;
      end else if (tb_state == SHIFT_DR) begin
        tb_dr = (mode == 2) ? {tdi_o, tb_dr[31:1]} : {31'b0, tdi_o};
        dr_n++;
      end
      tb_state = tb_next(tb_state, tms_o);
    end
  end

  always @(negedge tck_o) tdo_i = (mode == 1) ? 1'b1 : tb_dr[0];

  // Response monitor: each rsp_valid&rsp_ready transfer pops one expectation
  always @(negedge clk) begin
    if (trstn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h err %0b, expected no response", rsp_data, rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
      n_rsp++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    tck_cnt = 0; tms_hist = '0; ir_n = 0; ir_tdi = '0; dr_n = 0; tdi_bad = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tck"}, 64'(tck_o), 64'd0);
    chk({tag, "_tms"}, 64'(tms_o), 64'd1);
    chk({tag, "_tdi"}, 64'(tdi_o), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_tap_state"}, 64'(tap_state_o), 64'(TEST_LOGIC_RESET));
  endtask

  task automatic issue(input host_cmd_t op, input int len, input logic [31:0] data);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_op = op; cmd_len = LEN_W'(len); cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int base = n_rsp;
    int t = 0;
    while (n_rsp == base && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_rsp_seen"}, 64'(n_rsp != base), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int t;
    trstn = 1'b0; cmd_valid = 1'b0; cmd_op = HOST_RESET; cmd_len = '0; cmd_data = '0;
    rsp_ready = 1'b1; tdo_i = 1'b0; mode = 0; tb_dr = '0;
    clear_counts();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    trstn = 1'b1;
    #1 chk("cmd_ready_at_release", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    // RESET: 1,1,1,1,1,0 ending in RUN_TEST_IDLE
    clear_counts();
    exp_q.push_back('{data: 32'h0, err: 1'b0});
    issue(HOST_RESET, 0, 32'h0);
    wait_rsp("reset");
    chk("reset_tcks", 64'(tck_cnt), 64'd6);
    chk("reset_tms_seq", 64'(tms_hist[5:0]), 64'(6'b111110));
    chk("reset_tap", 64'(tap_state_o), 64'(RUN_TEST_IDLE));
    chk("reset_tck_idle", 64'(tck_o), 64'd0);

    // SHIFT_DR through bypass: captured 0 followed by tdi delayed one bit
    clear_counts();
    mode = 0;
    exp_q.push_back('{data: 32'h4A, err: 1'b0});
    issue(HOST_SHIFT_DR, 8, 32'hA5);
    wait_rsp("dr8");
    chk("dr8_tcks", 64'(tck_cnt), 64'd13);
    chk("dr8_shift_cycles", 64'(dr_n), 64'd8);
    chk("dr8_tdi_outside", 64'(tdi_bad), 64'd0);
    chk("dr8_tap", 64'(tap_state_o), 64'(RUN_TEST_IDLE));

    // SHIFT_IR with tdo tied high
    clear_counts();
    mode = 1; tdo_i = 1'b1;
    exp_q.push_back('{data: 32'hF, err: 1'b0});
    issue(HOST_SHIFT_IR, 4, 32'h5);
    wait_rsp("ir4");
    chk("ir4_tcks", 64'(tck_cnt), 64'd10);
    chk("ir4_shift_cycles", 64'(ir_n), 64'd4);
    chk("ir4_tdi_bits", 64'(ir_tdi[3:0]), 64'(4'b0101));
    chk("ir4_tdi_outside", 64'(tdi_bad), 64'd0);
    chk("ir4_tap", 64'(tap_state_o), 64'(RUN_TEST_IDLE));
    chk("ir4_tms_idle", 64'(tms_o), 64'd0);

    // Bad lengths: error response, no tck activity
    mode = 0;
    clear_counts();
    exp_q.push_back('{data: 32'h0, err: 1'b1});
    issue(HOST_SHIFT_DR, 0, 32'hFFFF_FFFF);
    wait_rsp("len0");
    chk("len0_tcks", 64'(tck_cnt), 64'd0);
    chk("len0_tap", 64'(tap_state_o), 64'(RUN_TEST_IDLE));
    clear_counts();
    exp_q.push_back('{data: 32'h0, err: 1'b1});
    issue(HOST_SHIFT_DR, MAX_LEN + 1, 32'hFFFF_FFFF);
    wait_rsp("len33");
    chk("len33_tcks", 64'(tck_cnt), 64'd0);
    chk("len33_tap", 64'(tap_state_o), 64'(RUN_TEST_IDLE));

    // Full-length DR readback with response backpressure
    clear_counts();
    mode = 2; rsp_ready = 1'b0;
    exp_q.push_back('{data: 32'hDEADBEEF, err: 1'b0});
    issue(HOST_SHIFT_DR, MAX_LEN, 32'h1234_5678);
    t = 0;
    while (!rsp_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("dr32_rsp_valid_seen", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_rsp("dr32");
    chk("dr32_tcks", 64'(tck_cnt), 64'd37);
    chk("dr32_shift_cycles", 64'(dr_n), 64'd32);
    chk("dr32_tap", 64'(tap_state_o), 64'(RUN_TEST_IDLE));

    // Async reset in the middle of a shift: no response, then a clean RESET
    clear_counts();
    issue(HOST_SHIFT_DR, MAX_LEN, 32'hCAFE_F00D);
    t = 0;
    while (dr_n < 10 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_reached_bit10", 64'(dr_n >= 10), 64'd1);
    #2 trstn = 1'b0;
    #1 check_reset_vals("abort");
    repeat (3) @(negedge clk);
    trstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    clear_counts();
    mode = 0;
    exp_q.push_back('{data: 32'h0, err: 1'b0});
    issue(HOST_RESET, 0, 32'h0);
    wait_rsp("reset2");
    chk("reset2_tcks", 64'(tck_cnt), 64'd6);
    chk("reset2_tms_seq", 64'(tms_hist[5:0]), 64'(6'b111110));
    chk("reset2_tap", 64'(tap_state_o), 64'(RUN_TEST_IDLE));

    repeat (4) @(negedge clk);
    chk("expect_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
